// File: rtl/asg_pkg.sv
// asg_pkg: shared types and constants for the series accumulator.
// Holds the FSM state enum, Q8.8 term format constants, default widths
// and helpers that give the saturation limits of a signed field of any width.
package asg_pkg;
    localparam int Q_TERM_W  = 16;
    localparam int Q_FRAC_W  = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_ACC_W = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction
endpackage

// File: rtl/asg_series_accumulator_if.sv
// asg_series_accumulator_if: term stream, control and result handshake bundle.
// master (host/generator side) drives start, n, term_valid, term_in, sum_ready;
// slave (accumulator) drives busy, sum_valid, sum_out, term_count, overflow.
interface asg_series_accumulator_if
    import asg_pkg::*;
#(
    parameter int TERM_W = Q_TERM_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ACC_W  = DEF_ACC_W
) ();
    logic              start;
    logic [CNT_W-1:0]  n;
    logic              term_valid;
    logic [TERM_W-1:0] term_in;
    logic              busy;
    logic              sum_valid;
    logic              sum_ready;
    logic [ACC_W-1:0]  sum_out;
    logic [CNT_W-1:0]  term_count;
    logic              overflow;

    modport master (
        output start, n, term_valid, term_in, sum_ready,
        input  busy, sum_valid, sum_out, term_count, overflow
    );

    modport slave (
        input  start, n, term_valid, term_in, sum_ready,
        output busy, sum_valid, sum_out, term_count, overflow
    );
endinterface

// File: rtl/asg_sat_add.sv
// asg_sat_add: combinational signed ACC_W adder with overflow flag.
// Ports: i_a, i_b operands; o_sum result; o_ovf signed overflow.
// ASG_ACC_SATURATE_EN: clamp to the signed limits on overflow, else wrap.
module asg_sat_add
    import asg_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic signed [ACC_W-1:0] i_a,
    input  logic signed [ACC_W-1:0] i_b,
    output logic signed [ACC_W-1:0] o_sum,
    output logic                    o_ovf
);
    logic signed [ACC_W-1:0] w_raw;

    assign w_raw = i_a + i_b;
    // Overflow only when both operands share a sign the result does not.
    assign o_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);
`ifdef ASG_ACC_SATURATE_EN
    assign o_sum = !o_ovf ? w_raw :
                   i_a[ACC_W-1] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W));
`else
    assign o_sum = w_raw;
`endif
endmodule

// File: rtl/asg_series_accumulator.sv
// asg_series_accumulator: sums a stream of signed Q8.8 terms into S_n.
// Ports: clk, reset (async, active-high); bus (slave modport) carries
// start/n/term_valid/term_in in and busy/sum_valid/sum_out/term_count/overflow
// out with a sum_valid/sum_ready result handshake.
// ASG_ACC_SATURATE_EN (in asg_sat_add): saturate instead of wrap on overflow.
module asg_series_accumulator
    import asg_pkg::*;
#(
    parameter int TERM_W = Q_TERM_W,
    parameter int FRAC_W = Q_FRAC_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input logic                     clk,
    input logic                     reset,
    asg_series_accumulator_if.slave bus
);
    state_t                  r_state;
    logic [CNT_W-1:0]        r_n;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_ovf;
    logic                    r_valid;
    logic                    r_busy;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_ovf;
    logic [CNT_W-1:0]        w_cnt_nx;

    if (ACC_W < TERM_W || FRAC_W >= TERM_W) begin : g_bad_cfg
        $error("asg_series_accumulator: need ACC_W >= TERM_W and FRAC_W < TERM_W");
    end

    assign w_term   = ACC_W'($signed(bus.term_in));
    assign w_cnt_nx = r_cnt + CNT_W'(1);

    asg_sat_add #(.ACC_W(ACC_W)) u_add (
        .i_a  (r_acc),
        .i_b  (w_term),
        .o_sum(w_sum),
        .o_ovf(w_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_n     <= bus.n;
                    r_cnt   <= '0;
                    r_acc   <= '0;
                    r_ovf   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_valid <= bus.n == '0;
                    r_state <= bus.n == '0 ? RESULT : ACCUM;
                end
                ACCUM: if (bus.term_valid) begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_nx;
                    r_ovf <= r_ovf | w_ovf;
                    // Final term: result is presented straight from the next cycle.
                    if (w_cnt_nx == r_n) begin
                        r_valid <= 1'b1;
                        r_state <= RESULT;
                    end
                end
                RESULT: if (bus.sum_ready) begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.sum_valid  = r_valid;
    assign bus.sum_out    = r_acc;
    assign bus.term_count = r_cnt;
    assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_asg_series_accumulator.sv
// tb_asg_series_accumulator: scoreboard bench driving a 24-bit and a 16-bit accumulator in parallel.
module tb_asg_series_accumulator;
    typedef struct {
        longint s;
        bit     o;
        int     cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        term_valid = 1'b0;
    logic        sum_ready = 1'b0;
    logic [7:0]  n = '0;
    logic [15:0] term_in = '0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q24[$];
    exp_t        q16[$];
    logic [15:0] terms[$];

    asg_series_accumulator_if #(.TERM_W(16), .CNT_W(8), .ACC_W(24)) b24 ();
    asg_series_accumulator_if #(.TERM_W(16), .CNT_W(8), .ACC_W(16)) b16 ();

    assign b24.start = start;
    assign b24.n = n;
    assign b24.term_valid = term_valid;
    assign b24.term_in = term_in;
    assign b24.sum_ready = sum_ready;
    assign b16.start = start;
    assign b16.n = n;
    assign b16.term_valid = term_valid;
    assign b16.term_in = term_in;
    assign b16.sum_ready = sum_ready;

    asg_series_accumulator #(.TERM_W(16), .FRAC_W(8), .CNT_W(8), .ACC_W(24)) dut24 (
        .clk(clk), .reset(reset), .bus(b24));
    asg_series_accumulator #(.TERM_W(16), .FRAC_W(8), .CNT_W(8), .ACC_W(16)) dut16 (
        .clk(clk), .reset(reset), .bus(b16));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: exact integer sum of the terms, folded back into a w-bit signed
    // range whenever it leaves it (wrap or clamp), flagging the overflow.
    function automatic exp_t model(input int w);
        exp_t   e;
        longint lo = -(longint'(1) <<< (w - 1));
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        e.s = 0;
        e.o = 0;
        e.cnt = terms.size();
        foreach (terms[i]) begin
            e.s += longint'($signed(terms[i]));
            if (e.s > hi || e.s < lo) begin
                e.o = 1;
`ifdef ASG_ACC_SATURATE_EN
                e.s = e.s > hi ? hi : lo;
`else
                e.s = e.s > hi ? e.s - (hi - lo + 1) : e.s + (hi - lo + 1);
`endif
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && b24.sum_valid) begin
            if (q24.size() == 0) chk("q24_size", 64'(q24.size()), 1);
            else begin
                chk("sum24", b24.sum_out, q24[0].s & 64'hFFFFFF);
                chk("ovf24", b24.overflow, q24[0].o);
                chk("cnt24", b24.term_count, q24[0].cnt);
                if (b24.sum_ready) void'(q24.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b16.sum_valid) begin
            if (q16.size() == 0) chk("q16_size", 64'(q16.size()), 1);
            else begin
                chk("sum16", b16.sum_out, q16[0].s & 64'hFFFF);
                chk("ovf16", b16.overflow, q16[0].o);
                chk("cnt16", b16.term_count, q16[0].cnt);
                if (b16.sum_ready) void'(q16.pop_front());
            end
        end
    end

    task automatic series(input int nn, input int gap, input int hold, input bit noise);
        q24.push_back(model(24));
        q16.push_back(model(16));
        sum_ready = hold == 0;
        start = 1'b1;
        n = 8'(nn);
        term_valid = 1'b0;
        @(posedge clk) #1;
        start = 1'b0;
        chk("busy_after_start", b24.busy, 1);
        foreach (terms[i]) begin
            repeat (gap > 0 ? $urandom_range(gap, 1) : 0) begin
                start = noise;
                n = 8'($urandom);
                @(posedge clk) #1;
            end
            start = noise;
            term_valid = 1'b1;
            term_in = terms[i];
            @(posedge clk) #1;
            term_valid = 1'b0;
            start = 1'b0;
        end
        chk("valid_latency24", b24.sum_valid, 1);
        chk("valid_latency16", b16.sum_valid, 1);
        if (noise) begin
            term_valid = 1'b1;
            term_in = 16'($urandom);
            start = 1'b1;
        end
        for (int k = 0; k < hold + 8 && b24.sum_valid; k++) begin
            if (k == hold) sum_ready = 1'b1;
            @(posedge clk) #1;
            term_valid = 1'b0;
            start = 1'b0;
        end
        chk("valid_drop", b24.sum_valid, 0);
        chk("busy_idle", b24.busy, 0);
        chk("count_hold", b24.term_count, 64'(nn));
        sum_ready = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, b24.busy, 0);
        chk({nm, "_valid"}, b24.sum_valid, 0);
        chk({nm, "_sum"}, b24.sum_out, 0);
        chk({nm, "_cnt"}, b24.term_count, 0);
        chk({nm, "_ovf"}, b24.overflow, 0);
        chk({nm, "_sum16"}, b16.sum_out, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        @(posedge clk) #1;

        terms = '{16'h0100, 16'h0180, 16'h0200, 16'h0280};
        series(4, 0, 0, 0);
        terms = '{16'hFF00, 16'h0000, 16'h0100};
        series(3, 3, 5, 0);
        terms = {};
        series(0, 0, 2, 0);
        terms = '{16'h7000, 16'h7000};
        series(2, 0, 0, 0);
        terms = '{16'h9000, 16'h9000, 16'h0100};
        series(3, 2, 1, 1);

        // Abort a series part-way: reset must clear everything without a clock edge.
        start = 1'b1;
        n = 8'd5;
        @(posedge clk) #1;
        start = 1'b0;
        term_valid = 1'b1;
        term_in = 16'h0100;
        repeat (2) @(posedge clk) #1;
        term_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk_zero("async_reset");
        @(posedge clk) #1;
        reset = 1'b0;
        @(posedge clk) #1;
        terms = '{16'h0080};
        series(1, 0, 0, 0);

        for (int r = 0; r < 40; r++) begin
            int nn = $urandom_range(12, 1);
            terms = {};
            repeat (nn) terms.push_back(16'($urandom));
            series(nn, $urandom_range(2, 0), $urandom_range(3, 0), 1'($urandom));
        end

        terms = {};
        repeat (255) terms.push_back(16'($urandom));
        series(255, 0, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("drained24", 64'(q24.size()), 0);
        chk("drained16", 64'(q16.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/asg_series_accumulator.md
Name: asg_series_accumulator

Overview:
- Downstream consumer of the arithmetic-sequence generator core.
- Accepts the stream of Q8.8 terms and accumulates their signed sum (arithmetic series S_n) in a widened fixed-point accumulator.
- Presents the result to the host/readout stage over a valid/ready handshake.
- Reports term count and a sticky overflow flag.

Parameters:
- TERM_W, 16: term width, signed Q8.8.
- FRAC_W, 8: fractional bits. Informational only; the binary point of sum_out equals that of term_in.
- CNT_W, 8: width of the term-count and n fields. Maximum n is 2^CNT_W-1.
- ACC_W, 24: accumulator width, signed. Must be at least TERM_W. The default 24 cannot overflow for n≤255.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new series. Honoured only in IDLE.
- n  in  CNT_W  number of terms expected. Sampled on the accepted start.
- term_valid  in  1  term_in carries a new term this cycle.
- term_in  in  TERM_W  signed Q8.8 term from the generator.
- busy  out  1  high in ACCUM and RESULT.
- sum_valid  out  1  sum_out is valid. Held until accepted.
- sum_ready  in  1  downstream accepts the sum.
- sum_out  out  ACC_W  signed Q(ACC_W-8).8 accumulated sum.
- term_count  out  CNT_W  number of terms accumulated in the current series.
- overflow  out  1  sticky: signed overflow occurred in the current series.

Behaviour:
- Reset (asynchronous, any state, including mid-series):
  - State goes to IDLE.
  - busy=0, sum_valid=0, sum_out=0, term_count=0, overflow=0, accumulator=0.
  - Any partial sum is discarded.
- FSM has three states: IDLE, ACCUM, RESULT. State is encoded in a 2-bit register.
- IDLE:
  - On start=1: latch n, clear the accumulator, term_count and overflow.
  - If the latched n is 0, go to RESULT (sum 0). Otherwise go to ACCUM.
  - term_valid is ignored.
- ACCUM:
  - Each cycle with term_valid=1: acc <= acc + sign_extend(term_in) and term_count++.
  - When that accepted term makes term_count equal to n, go to RESULT on the same edge.
  - start is ignored. Terms are accepted every cycle, with no backpressure.
- RESULT:
  - sum_valid=1 and sum_out=acc, both held stable until sum_ready=1.
  - On the cycle where sum_valid and sum_ready are both 1, the transfer completes and the state goes to IDLE.
  - sum_valid drops the next cycle. sum_out and term_count retain their last values.
  - start and term_valid are ignored.
- Latency: sum_valid rises in the cycle immediately after the edge that accepts the final term (one register stage).
- Overflow:
  - Detected when both operands have equal sign and the result sign differs.
  - Once set, overflow stays set until the next accepted start or a reset.
  - Default build: the accumulator wraps in two's complement.
- Simultaneous events:
  - start in the same cycle as a RESULT handshake is ignored. A new start is needed in IDLE.
  - A term_valid arriving after n terms have been accepted is dropped.

Optional Feature:
- Macro: ASG_ACC_SATURATE_EN.
- When defined: on overflow the accumulator clamps to the most positive value (2^(ACC_W-1)-1) or the most negative value (-2^(ACC_W-1)), and overflow is still set.
- When undefined: two's-complement wrap, with overflow set.

Decomposition:
- Shared package asg_pkg holds:
  - the state enum (IDLE/ACCUM/RESULT, 2-bit);
  - Q8.8 constants: TERM_W=16, FRAC_W=8;
  - default CNT_W and ACC_W;
  - the saturation limit constants.
- One sub-module, asg_sat_add: combinational signed ACC_W adder that outputs the sum and an overflow flag. Clamping is compiled in under ASG_ACC_SATURATE_EN.
- The FSM and registers stay in the top module.

Test Plan:
1. Basic series: start with n=4, then terms 0x0100, 0x0180, 0x0200, 0x0280 on consecutive cycles, sum_ready=1 → sum_valid one cycle after the 4th term, sum_out=0x000700 (7.0), term_count=4, overflow=0.
2. Gapped input and backpressure: n=3 with terms 0xFF00 (-1.0), 0x0000, 0x0100 separated by idle cycles, sum_ready held 0 for 5 cycles → sum_out=0x000000 held stable with sum_valid=1 until sum_ready, then IDLE and busy=0.
3. n=0: start with n=0 → RESULT next cycle, sum_out=0, term_count=0, no terms consumed.
4. Overflow with ACC_W=16: n=2, terms 0x7000, 0x7000 → without the macro sum_out=0xE000 and overflow=1; with ASG_ACC_SATURATE_EN sum_out=0x7FFF and overflow=1.
5. Reset mid-series: n=5, assert reset after 2 terms → all outputs 0 asynchronously. A new start with n=1 and term 0x0080 → sum_out=0x000080.
6. Ignored inputs: start pulsed during ACCUM, and an extra term_valid after n terms → the sum is unchanged and term_count does not exceed n.
